// File: rtl/bsg_cache_dma_rr_arbiter.sv
// rtl/bsg_cache_dma_rr_arbiter.sv - round-robin share of one memory DMA channel among several cache DMA ports.
// Grant ids are queued in read/write tag FIFOs that steer fill data and pull write data in grant order.

module bsg_cache_dma_rr_arbiter_tag_fifo #(
  parameter int width_p = 2,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               nonempty_o,
  output logic               full_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w-1:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = (wptr_q == ptr_w'(els_p - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop_i) begin
      rptr_d = (rptr_q == ptr_w'(els_p - 1)) ? '0 : rptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign data_o     = mem_q[rptr_q];
  assign nonempty_o = (count_q != '0);
  assign full_o     = (count_q == cnt_w'(els_p));

endmodule

module bsg_cache_dma_rr_arbiter #(
  parameter int num_cache_p           = 4,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int tag_fifo_els_p        = 4
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_cache_p*(addr_width_p+1)-1:0] cache_dma_pkt_i,
  input  logic [num_cache_p-1:0]                  cache_dma_pkt_v_i,
  output logic [num_cache_p-1:0]                  cache_dma_pkt_yumi_o,
  output logic [num_cache_p*data_width_p-1:0]     cache_dma_data_o,
  output logic [num_cache_p-1:0]                  cache_dma_data_v_o,
  input  logic [num_cache_p-1:0]                  cache_dma_data_ready_and_i,
  input  logic [num_cache_p*data_width_p-1:0]     cache_dma_data_i,
  input  logic [num_cache_p-1:0]                  cache_dma_data_v_i,
  output logic [num_cache_p-1:0]                  cache_dma_data_yumi_o,
  output logic [addr_width_p:0]                   mem_dma_pkt_o,
  output logic                                    mem_dma_pkt_v_o,
  input  logic                                    mem_dma_pkt_yumi_i,
  input  logic [data_width_p-1:0]                 mem_dma_data_i,
  input  logic                                    mem_dma_data_v_i,
  output logic                                    mem_dma_data_ready_and_o,
  output logic [data_width_p-1:0]                 mem_dma_data_o,
  output logic                                    mem_dma_data_v_o,
  input  logic                                    mem_dma_data_yumi_i
);

  localparam int id_w  = (num_cache_p > 1) ? $clog2(num_cache_p) : 1;
  localparam int cnt_w = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
  localparam int pkt_w = addr_width_p + 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(block_size_in_words_p - 1);

  logic [id_w-1:0]  rr_q, rr_d;
  logic [id_w-1:0]  winner;
  logic             any_v;
  int               idx;
  logic [pkt_w-1:0] win_pkt;
  logic             pkt_accept;

  logic [id_w-1:0]  rd_tag, wr_tag;
  logic             rd_ne, wr_ne, rd_full, wr_full;
  logic             rd_push, wr_push, rd_pop, wr_pop;
  logic             rd_hs, wr_hs;
  logic [cnt_w-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  // First requester at or above the pointer, wrapping modulo num_cache_p.
  always_comb begin
    any_v  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < num_cache_p; i++) begin
      idx = (int'(rr_q) + i) % num_cache_p;
      if (!any_v && cache_dma_pkt_v_i[idx]) begin
        any_v  = 1'b1;
        winner = id_w'(idx);
      end
    end
  end

  assign win_pkt         = cache_dma_pkt_i[winner*pkt_w +: pkt_w];
  assign mem_dma_pkt_o   = win_pkt;
  assign mem_dma_pkt_v_o = ~reset_i & any_v & ~rd_full & ~wr_full;
  assign pkt_accept      = mem_dma_pkt_v_o & mem_dma_pkt_yumi_i;
  assign rd_push         = pkt_accept & ~win_pkt[addr_width_p];
  assign wr_push         = pkt_accept &  win_pkt[addr_width_p];

  always_comb begin
    cache_dma_pkt_yumi_o = '0;
    rr_d                 = rr_q;
    if (pkt_accept) begin
      cache_dma_pkt_yumi_o[winner] = 1'b1;
      rr_d = (winner == id_w'(num_cache_p - 1)) ? '0 : winner + 1'b1;
    end
  end

  bsg_cache_dma_rr_arbiter_tag_fifo #(
    .width_p(id_w),
    .els_p  (tag_fifo_els_p)
  ) rd_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (rd_push),
    .data_i    (winner),
    .pop_i     (rd_pop),
    .data_o    (rd_tag),
    .nonempty_o(rd_ne),
    .full_o    (rd_full)
  );

  bsg_cache_dma_rr_arbiter_tag_fifo #(
    .width_p(id_w),
    .els_p  (tag_fifo_els_p)
  ) wr_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (wr_push),
    .data_i    (winner),
    .pop_i     (wr_pop),
    .data_o    (wr_tag),
    .nonempty_o(wr_ne),
    .full_o    (wr_full)
  );

  // Fill data is broadcast; only the head cache sees valid.
  assign cache_dma_data_o         = {num_cache_p{mem_dma_data_i}};
  assign mem_dma_data_ready_and_o = ~reset_i & rd_ne & cache_dma_data_ready_and_i[rd_tag];
  assign rd_hs                    = mem_dma_data_v_i & mem_dma_data_ready_and_o;
  assign rd_pop                   = rd_hs & (rd_cnt_q == last_cnt);

  always_comb begin
    cache_dma_data_v_o = '0;
    if (~reset_i & rd_ne & mem_dma_data_v_i) begin
      cache_dma_data_v_o[rd_tag] = 1'b1;
    end
  end

  assign mem_dma_data_o   = cache_dma_data_i[wr_tag*data_width_p +: data_width_p];
  assign mem_dma_data_v_o = ~reset_i & wr_ne & cache_dma_data_v_i[wr_tag];
  assign wr_hs            = mem_dma_data_v_o & mem_dma_data_yumi_i;
  assign wr_pop           = wr_hs & (wr_cnt_q == last_cnt);

  always_comb begin
    cache_dma_data_yumi_o = '0;
    if (wr_hs) begin
      cache_dma_data_yumi_o[wr_tag] = 1'b1;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_hs) begin
      rd_cnt_d = (rd_cnt_q == last_cnt) ? '0 : rd_cnt_q + 1'b1;
    end
    if (wr_hs) begin
      wr_cnt_d = (wr_cnt_q == last_cnt) ? '0 : wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q     <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rr_q     <= rr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_cache_dma_rr_arbiter.sv
// tb/tb_bsg_cache_dma_rr_arbiter.sv - scoreboard bench for bsg_cache_dma_rr_arbiter.

module tb_bsg_cache_dma_rr_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BS = 4;
  localparam int FE = 2;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic [NC*(AW+1)-1:0]  cache_dma_pkt_i;
  logic [NC-1:0]         cache_dma_pkt_v_i;
  logic [NC-1:0]         cache_dma_pkt_yumi_o;
  logic [NC*DW-1:0]      cache_dma_data_o;
  logic [NC-1:0]         cache_dma_data_v_o;
  logic [NC-1:0]         cache_dma_data_ready_and_i;
  logic [NC*DW-1:0]      cache_dma_data_i;
  logic [NC-1:0]         cache_dma_data_v_i;
  logic [NC-1:0]         cache_dma_data_yumi_o;
  logic [AW:0]           mem_dma_pkt_o;
  logic                  mem_dma_pkt_v_o;
  logic                  mem_dma_pkt_yumi_i;
  logic [DW-1:0]         mem_dma_data_i;
  logic                  mem_dma_data_v_i;
  logic                  mem_dma_data_ready_and_o;
  logic [DW-1:0]         mem_dma_data_o;
  logic                  mem_dma_data_v_o;
  logic                  mem_dma_data_yumi_i;

  logic [AW:0]   pkt_a   [NC];
  logic [DW-1:0] wdata_a [NC];
  logic [63:0]   ctl_o;

  typedef struct {
    int          id;
    logic [63:0] val;
  } exp_t;

  int   grant_q [$];
  exp_t fill_q  [$];
  exp_t wr_q    [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    cache_dma_pkt_i  = '0;
    cache_dma_data_i = '0;
    for (int i = 0; i < NC; i++) begin
      cache_dma_pkt_i[i*(AW+1) +: (AW+1)] = pkt_a[i];
      cache_dma_data_i[i*DW +: DW]        = wdata_a[i];
    end
  end

  assign ctl_o = 64'({cache_dma_pkt_yumi_o, cache_dma_data_v_o, cache_dma_data_yumi_o,
                      mem_dma_pkt_v_o, mem_dma_data_ready_and_o, mem_dma_data_v_o});

  bsg_cache_dma_rr_arbiter #(
    .num_cache_p          (NC),
    .addr_width_p         (AW),
    .data_width_p         (DW),
    .block_size_in_words_p(BS),
    .tag_fifo_els_p       (FE)
  ) dut (
    .clk_i                     (clk),
    .reset_i                   (reset_i),
    .cache_dma_pkt_i           (cache_dma_pkt_i),
    .cache_dma_pkt_v_i         (cache_dma_pkt_v_i),
    .cache_dma_pkt_yumi_o      (cache_dma_pkt_yumi_o),
    .cache_dma_data_o          (cache_dma_data_o),
    .cache_dma_data_v_o        (cache_dma_data_v_o),
    .cache_dma_data_ready_and_i(cache_dma_data_ready_and_i),
    .cache_dma_data_i          (cache_dma_data_i),
    .cache_dma_data_v_i        (cache_dma_data_v_i),
    .cache_dma_data_yumi_o     (cache_dma_data_yumi_o),
    .mem_dma_pkt_o             (mem_dma_pkt_o),
    .mem_dma_pkt_v_o           (mem_dma_pkt_v_o),
    .mem_dma_pkt_yumi_i        (mem_dma_pkt_yumi_i),
    .mem_dma_data_i            (mem_dma_data_i),
    .mem_dma_data_v_i          (mem_dma_data_v_i),
    .mem_dma_data_ready_and_o  (mem_dma_data_ready_and_o),
    .mem_dma_data_o            (mem_dma_data_o),
    .mem_dma_data_v_o          (mem_dma_data_v_o),
    .mem_dma_data_yumi_i       (mem_dma_data_yumi_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] oh(input int id);
    logic [NC-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  task automatic push_fill(input int id, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) fill_q.push_back('{id, 64'(base + DW'(k))});
  endtask

  task automatic push_wr(input int id, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) wr_q.push_back('{id, 64'(base + DW'(k))});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input int n, input bit hold, output int cyc);
    int cnt;
    logic [NC-1:0] y;
    cnt = 0;
    cyc = 0;
    mem_dma_pkt_yumi_i = 1'b1;
    while (cnt < n && cyc < 200) begin
      @(negedge clk);
      y = cache_dma_pkt_yumi_o;
      tick();
      cyc++;
      if (|y) cnt++;
      if (!hold) cache_dma_pkt_v_i = cache_dma_pkt_v_i & ~y;
      if (cnt == n) mem_dma_pkt_yumi_i = 1'b0;
    end
    mem_dma_pkt_yumi_i = 1'b0;
    check("grant_done", 64'(cnt), 64'(n));
  endtask

  task automatic send_fill(input int n, input logic [DW-1:0] base, output int cyc);
    int idx;
    logic hs;
    idx = 0;
    cyc = 0;
    mem_dma_data_i   = base;
    mem_dma_data_v_i = 1'b1;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      hs = mem_dma_data_ready_and_o;
      tick();
      cyc++;
      if (hs) idx++;
      mem_dma_data_i = base + DW'(idx);
    end
    mem_dma_data_v_i = 1'b0;
    check("fill_done", 64'(idx), 64'(n));
  endtask

  task automatic send_wr(input int c, input int n, input logic [DW-1:0] base, input bit toggle,
                         output int cyc);
    int idx;
    bit phase;
    logic hs;
    idx   = 0;
    cyc   = 0;
    phase = 1'b1;
    wdata_a[c]            = base;
    cache_dma_data_v_i[c] = 1'b1;
    mem_dma_data_yumi_i   = 1'b1;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      hs = cache_dma_data_yumi_o[c];
      tick();
      cyc++;
      if (hs) idx++;
      wdata_a[c] = base + DW'(idx);
      if (toggle) phase = ~phase;
      mem_dma_data_yumi_i = phase;
    end
    check("wr_done", 64'(idx), 64'(n));
  endtask

  // Scoreboard: every handshake pops the oldest expectation on its path.
  int   mon_id;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset_i) begin
      if (mem_dma_pkt_v_o && mem_dma_pkt_yumi_i) begin
        if (grant_q.size() == 0) check("grant_unexpected", 64'(grant_q.size()), 64'd1);
        else begin
          mon_id = grant_q.pop_front();
          check("grant_yumi", 64'(cache_dma_pkt_yumi_o), 64'(oh(mon_id)));
          check("grant_pkt", 64'(mem_dma_pkt_o), 64'(pkt_a[mon_id]));
        end
      end else check("idle_pkt_yumi", 64'(cache_dma_pkt_yumi_o), 64'd0);
      if (mem_dma_data_v_i && mem_dma_data_ready_and_o) begin
        if (fill_q.size() == 0) check("fill_unexpected", 64'(fill_q.size()), 64'd1);
        else begin
          mon_e = fill_q.pop_front();
          check("fill_v", 64'(cache_dma_data_v_o), 64'(oh(mon_e.id)));
          check("fill_data", 64'(cache_dma_data_o[mon_e.id*DW +: DW]), mon_e.val);
        end
      end
      if (mem_dma_data_v_o && mem_dma_data_yumi_i) begin
        if (wr_q.size() == 0) check("wr_unexpected", 64'(wr_q.size()), 64'd1);
        else begin
          mon_e = wr_q.pop_front();
          check("wr_data", 64'(mem_dma_data_o), mon_e.val);
          check("wr_yumi", 64'(cache_dma_data_yumi_o), 64'(oh(mon_e.id)));
        end
      end else check("idle_wr_yumi", 64'(cache_dma_data_yumi_o), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c1, c2;
    reset_i                    = 1'b1;
    cache_dma_pkt_v_i          = '0;
    cache_dma_data_ready_and_i = '0;
    cache_dma_data_v_i         = '0;
    mem_dma_pkt_yumi_i         = 1'b0;
    mem_dma_data_i             = '0;
    mem_dma_data_v_i           = 1'b0;
    mem_dma_data_yumi_i        = 1'b0;
    for (int i = 0; i < NC; i++) begin
      pkt_a[i]   = '0;
      wdata_a[i] = '0;
    end
    repeat (3) tick();
    check("reset_outputs", ctl_o, 64'd0);

    // Empty FIFOs keep every handshake output low even with data pressure.
    reset_i                    = 1'b0;
    cache_dma_data_ready_and_i = '1;
    mem_dma_data_v_i           = 1'b1;
    cache_dma_data_v_i         = '1;
    mem_dma_data_yumi_i        = 1'b1;
    #1;
    check("empty_outputs", ctl_o, 64'd0);
    tick();
    mem_dma_data_v_i    = 1'b0;
    cache_dma_data_v_i  = '0;
    mem_dma_data_yumi_i = 1'b0;

    // Two simultaneous reads: cache0 then cache1, fill data split by block.
    pkt_a[0] = {1'b0, 32'h100};
    pkt_a[1] = {1'b0, 32'h200};
    grant_q.push_back(0);
    grant_q.push_back(1);
    cache_dma_pkt_v_i = 4'b0011;
    grant(2, 1'b0, c1);
    check("t1_grant_cycles", 64'(c1), 64'd2);
    push_fill(0, 4, 32'hD000);
    push_fill(1, 4, 32'hD004);
    send_fill(8, 32'hD000, c1);
    check("t1_fill_cycles", 64'(c1), 64'd8);

    // Write from cache0 with memory yumi every other cycle.
    pkt_a[0] = {1'b1, 32'h40};
    grant_q.push_back(0);
    cache_dma_pkt_v_i = 4'b0001;
    grant(1, 1'b0, c1);
    push_wr(0, 4, 32'hA);
    send_wr(0, 4, 32'hA, 1'b1, c1);
    check("t2_wr_cycles", 64'(c1), 64'd7);
    check("t2_wr_fifo_empty", 64'(mem_dma_data_v_o), 64'd0);
    cache_dma_data_v_i  = '0;
    mem_dma_data_yumi_i = 1'b0;

    // Full read FIFO blocks cache2 until the first block drains.
    pkt_a[0] = {1'b0, 32'h300};
    pkt_a[1] = {1'b0, 32'h310};
    grant_q.push_back(1);
    grant_q.push_back(0);
    cache_dma_pkt_v_i = 4'b0011;
    grant(2, 1'b0, c1);
    pkt_a[2] = {1'b0, 32'h320};
    cache_dma_pkt_v_i = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      check("t3_blocked", 64'(mem_dma_pkt_v_o), 64'd0);
    end
    tick();
    push_fill(1, 4, 32'hE0);
    send_fill(4, 32'hE0, c1);
    check("t3_fill_cycles", 64'(c1), 64'd4);
    check("t3_pkt_v_rise", 64'(mem_dma_pkt_v_o), 64'd1);
    grant_q.push_back(2);
    grant(1, 1'b0, c1);
    check("t3_grant_cycles", 64'(c1), 64'd1);
    push_fill(0, 4, 32'hE4);
    push_fill(2, 4, 32'hE8);
    send_fill(8, 32'hE4, c1);

    // Concurrent cache1 fill and cache0 write drain.
    pkt_a[0] = {1'b1, 32'h80};
    pkt_a[1] = {1'b0, 32'h400};
    grant_q.push_back(0);
    grant_q.push_back(1);
    cache_dma_pkt_v_i = 4'b0011;
    grant(2, 1'b0, c1);
    push_fill(1, 4, 32'hF0);
    push_wr(0, 4, 32'h60);
    fork
      send_fill(4, 32'hF0, c1);
      send_wr(0, 4, 32'h60, 1'b0, c2);
    join
    check("t4_fill_cycles", 64'(c1), 64'd4);
    check("t4_wr_cycles", 64'(c2), 64'd4);
    cache_dma_data_v_i  = '0;
    mem_dma_data_yumi_i = 1'b0;

    // Reset in the middle of a fill block.
    pkt_a[3] = {1'b0, 32'h500};
    grant_q.push_back(3);
    cache_dma_pkt_v_i = 4'b1000;
    grant(1, 1'b0, c1);
    push_fill(3, 2, 32'h70);
    send_fill(2, 32'h70, c1);
    reset_i             = 1'b1;
    mem_dma_data_v_i    = 1'b1;
    cache_dma_data_v_i  = '1;
    mem_dma_data_yumi_i = 1'b1;
    pkt_a[1]            = {1'b0, 32'h600};
    cache_dma_pkt_v_i   = 4'b0010;
    mem_dma_pkt_yumi_i  = 1'b1;
    #1;
    check("t5_reset_cycle", ctl_o, 64'd0);
    tick();
    reset_i            = 1'b0;
    cache_dma_pkt_v_i  = '0;
    mem_dma_pkt_yumi_i = 1'b0;
    #1;
    check("t5_after_reset", ctl_o, 64'd0);
    mem_dma_data_v_i    = 1'b0;
    cache_dma_data_v_i  = '0;
    mem_dma_data_yumi_i = 1'b0;
    grant_q.push_back(1);
    cache_dma_pkt_v_i = 4'b0010;
    grant(1, 1'b0, c1);
    check("t5_regrant_cycles", 64'(c1), 64'd1);
    push_fill(1, 4, 32'h80);
    send_fill(4, 32'h80, c1);
    check("t5_fill_cycles", 64'(c1), 64'd4);

    // All caches request continuously from a fresh pointer.
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
    for (int i = 0; i < NC; i++) pkt_a[i] = {1'b0, 32'hA00 + 32'(i * 16)};
    grant_q.push_back(0);
    grant_q.push_back(1);
    grant_q.push_back(2);
    grant_q.push_back(3);
    grant_q.push_back(0);
    for (int j = 0; j < 20; j++) fill_q.push_back('{(j / 4) % NC, 64'(32'h900 + j)});
    cache_dma_pkt_v_i = '1;
    fork
      grant(5, 1'b1, c1);
      send_fill(20, 32'h900, c2);
    join
    cache_dma_pkt_v_i = '0;
    tick();

    check("grant_q_drained", 64'(grant_q.size()), 64'd0);
    check("fill_q_drained", 64'(fill_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
